// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: mono sample duplicated on both slots, one sample_req per frame,
// sticky underrun when a frame has to repeat a stale sample.
module i2s_tx_serializer #(
    parameter int SAMPLE_BITS   = 16,
    parameter int SLOT_BITS     = 32,
    parameter int MCLK_PER_BCLK = 4
) (
    input  logic                   mclk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   valid,
    input  logic [SAMPLE_BITS-1:0] current_sample,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   sdata,
    output logic                   sample_req,
    output logic                   underrun
);
    localparam int DIV_W = (MCLK_PER_BCLK > 2) ? $clog2(MCLK_PER_BCLK) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = (SAMPLE_BITS > 2) ? $clog2(SAMPLE_BITS) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div, div_n;
    logic [BIT_W-1:0]       bit_cnt, bit_n, pos;
    logic [IDX_W-1:0]       idx;
    logic [SAMPLE_BITS-1:0] hold, frame;
    logic                   fresh;
    logic                   load;
    logic                   bclk_n, lrclk_n, sdata_n;

    // Outputs are registered from the next counter values, so they line up with div/bit_cnt.
    always_comb begin
        div_n   = '0;
        bit_n   = '0;
        load    = 1'b0;
        pos     = '0;
        idx     = '0;
        sdata_n = 1'b0;
        if (state == ST_IDLE) begin
            load = 1'b1;
        end else if (div == DIV_W'(MCLK_PER_BCLK - 1)) begin
            if (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) begin
                load = 1'b1;
            end else begin
                bit_n = bit_cnt + BIT_W'(1);
            end
        end else begin
            div_n = div + DIV_W'(1);
            bit_n = bit_cnt;
        end
        bclk_n  = (div_n >= DIV_W'(MCLK_PER_BCLK / 2));
        lrclk_n = (bit_n >= BIT_W'(SLOT_BITS));
        pos     = lrclk_n ? (bit_n - BIT_W'(SLOT_BITS)) : bit_n;
        idx     = IDX_W'(SAMPLE_BITS - int'(pos));
        // Slot position 0 is the I2S one-BCLK delay; frame is only read from position 1 on.
        if (pos >= BIT_W'(1) && pos <= BIT_W'(SAMPLE_BITS)) begin
            sdata_n = frame[idx];
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            hold       <= '0;
            frame      <= '0;
            fresh      <= 1'b0;
        end else begin
            if (enable) begin
                state      <= ST_RUN;
                div        <= div_n;
                bit_cnt    <= bit_n;
                bclk       <= bclk_n;
                lrclk      <= lrclk_n;
                sdata      <= sdata_n;
                sample_req <= load;
                if (load) begin
                    frame <= hold;
                    if (!fresh) begin
                        underrun <= 1'b1;
                    end
                end
            end else begin
                state      <= ST_IDLE;
                div        <= '0;
                bit_cnt    <= '0;
                bclk       <= 1'b0;
                lrclk      <= 1'b0;
                sdata      <= 1'b0;
                sample_req <= 1'b0;
            end
            // A valid in the load cycle wins over the clear and survives to the next frame.
            if (valid) begin
                hold  <= current_sample;
                fresh <= 1'b1;
            end else if (enable && load) begin
                fresh <= 1'b0;
            end
        end
    end
endmodule
